// File: rtl/hdu_writeback8_pkg.sv
// Shared types and helpers for the HDU write-back issuer.
package hdu_writeback8_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 3;

  typedef logic [LANE_W-1:0] lane_idx_t;

  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int unsigned bank_w);
    return addr & ((32'd1 << bank_w) - 32'd1);
  endfunction

  // Position of a lane in the round-robin order that starts at base.
  function automatic lane_idx_t lane_pos(input lane_idx_t lane, input lane_idx_t base);
    return lane - base;
  endfunction

endpackage

// File: rtl/hdu_writeback8_if.sv
// Update-in / write-out bundle between the lane pipelines, the issuer and the HDU.
interface hdu_writeback8_if
  import hdu_writeback8_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);

  logic [LANES*ADDR_W-1:0] up_addr;
  logic [LANES*DATA_W-1:0] up_data;
  logic [LANES-1:0]        up_valid;
  logic [LANES-1:0]        up_ready;
  logic [LANES*ADDR_W-1:0] Waddr;
  logic [LANES*DATA_W-1:0] Wdata;
  logic [LANES-1:0]        Waddr_valid;
  logic                    idle;
  logic [31:0]             conflict_cnt;

  modport master (
    output up_addr, up_data, up_valid,
    input  up_ready, Waddr, Wdata, Waddr_valid, idle, conflict_cnt
  );

  modport slave (
    input  up_addr, up_data, up_valid,
    output up_ready, Waddr, Wdata, Waddr_valid, idle, conflict_cnt
  );

endinterface

// File: rtl/hdu_writeback8_wb_lane_fifo.sv
// Per-lane registered FIFO; count kept separately so full and empty never alias.
module wb_lane_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // Full refuses a push even while popping: ready never depends on pop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/hdu_writeback8.sv
// Write-back issuer: buffers lane updates and issues at most one write per bank per cycle.
module hdu_writeback8
  import hdu_writeback8_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned BANK_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  hdu_writeback8_if.slave bus
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [LANES-1:0]        req, grant, full, empty, push, nonzero;
  logic [ADDR_W-1:0]       head_addr [LANES];
  logic [DATA_W-1:0]       head_data [LANES];
  logic [31:0]             head_bank [LANES];
  lane_idx_t               rr_q, rr_d;
  logic [31:0]             conflict_q, conflict_d;
  logic [LANES-1:0]        wvalid_q;
  logic [LANES*ADDR_W-1:0] waddr_q;
  logic [LANES*DATA_W-1:0] wdata_q;
  logic                    denial;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [ENT_W-1:0] head;
    logic [CNT_W-1:0] count;
    logic             g;

    assign push[k] = bus.up_valid[k] & ~full[k];

    wb_lane_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (grant[k]),
      .din   ({bus.up_addr[k*ADDR_W +: ADDR_W], bus.up_data[k*DATA_W +: DATA_W]}),
      .head  (head),
      .count (count),
      .full  (full[k]),
      .empty (empty[k])
    );

    assign req[k]       = ~empty[k];
    assign nonzero[k]   = (count != '0);
    assign head_addr[k] = head[ENT_W-1 -: ADDR_W];
    assign head_data[k] = head[DATA_W-1:0];
    assign head_bank[k] = bank_of(32'(head_addr[k]), BANK_W);

    // Lose the bank to any requester that comes earlier in round-robin order.
    always_comb begin
      g = req[k];
      for (int j = 0; j < LANES; j++) begin
        if (j != k && req[j] && head_bank[j] == head_bank[k] &&
            lane_pos(lane_idx_t'(j), rr_q) < lane_pos(lane_idx_t'(k), rr_q)) begin
          g = 1'b0;
        end
      end
    end

    assign grant[k] = g;
  end

  always_comb begin
    denial     = |(req & ~grant);
    rr_d       = rr_q + lane_idx_t'(denial);
    conflict_d = conflict_q;
    if (denial && conflict_q != '1) conflict_d = conflict_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      conflict_q <= '0;
      wvalid_q   <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      rr_q       <= rr_d;
      conflict_q <= conflict_d;
      wvalid_q   <= grant;
      for (int k = 0; k < LANES; k++) begin
        if (grant[k]) begin
          waddr_q[k*ADDR_W +: ADDR_W] <= head_addr[k];
          wdata_q[k*DATA_W +: DATA_W] <= head_data[k];
        end
      end
    end
  end

  assign bus.up_ready     = ~full;
  assign bus.Waddr        = waddr_q;
  assign bus.Wdata        = wdata_q;
  assign bus.Waddr_valid  = wvalid_q;
  assign bus.conflict_cnt = conflict_q;
  assign bus.idle         = ~|nonzero & ~|wvalid_q;

endmodule
